hub75_line_driver: RTL and testbench
====================================

// Module: hub75_line_driver
// PURPOSE
//  Consumer end of the frame manager's column stream. Accepts one scanline pair:
//  two 64-pixel columns, with col_num addressing columns col_num and col_num+SCAN_RATE.
//  Drives the HUB75 panel pins: serial RGB shift, latch, output-enable and row address.
//  Uses 3-plane binary-coded modulation of 3-bit colour channels. Raises hub75_ready when it can take the next pair.
// PARAMETERS
//  NUM_ROWS       64  pixels per column (shift length per plane)
//  SCAN_RATE      32  scanlines; addr width = $clog2(SCAN_RATE)
//  RGB_RES        9   bits per pixel: [8:6]=R, [5:3]=G, [2:0]=B
//  BASE_OE_CYCLES 8   OE-low cycles for plane 0 (LSB); plane p shows BASE_OE_CYCLES<<p; legal >=1
// PORTS
//  clk_in       in   1                        system clock
//  rst_in       in   1                        asynchronous, active-low reset (0 = reset)
//  columns      in   [1:0][NUM_ROWS-1:0][RGB_RES-1:0]  [0]=upper-half column, [1]=lower-half column
//  col_num      in   $clog2(SCAN_RATE)        scanline address of columns[0]
//  data_valid   in   1                        columns/col_num valid; level, may be held high
//  hub75_ready  out  1                        driver accepts a pair on this edge if data_valid=1
//  r1,g1,b1     out  1                        serial data, upper half
//  r2,g2,b2     out  1                        serial data, lower half
//  sclk         out  1                        panel shift clock (clk_in/2 while shifting)
//  latch        out  1                        panel latch strobe
//  oe_n         out  1                        panel output enable, active-low (1 = blank)
//  addr         out  $clog2(SCAN_RATE)        panel row address A..E
// BEHAVIOUR
//  - Reset: hub75_ready=0, sclk=0, latch=0, oe_n=1, addr=0, r/g/b1/2=0, state=IDLE, plane=0.
//    Async assertion blanks the panel immediately; first edge after release sets hub75_ready=1.
//  - Capture: on a posedge with hub75_ready&&data_valid, register columns and col_num into the line buffer.
//    hub75_ready drops next cycle. data_valid while !hub75_ready is ignored; no queueing.
//  - FSM IDLE -> SHIFT -> LATCH -> SHOW -> (SHIFT with plane+1 | IDLE after plane 2).
//  - SHIFT: 2*NUM_ROWS cycles. Pixel i is driven with sclk=0, then sclk=1 on the next cycle.
//    Order is i=0..NUM_ROWS-1. Data bit = channel bit [plane] of each colour; oe_n=1 throughout.
//  - LATCH: 1 cycle; sclk=0, oe_n=1, latch=1. addr updates to the captured col_num this cycle.
//  - SHOW: oe_n=0 for exactly BASE_OE_CYCLES<<plane cycles; latch=0, sclk=0, data outputs 0.
//  - Timing per pair (default): 3*(128+1) + 8*(1+2+4) = 443 cycles from the first SHIFT cycle to the end of the last SHOW.
//  - Exit: after plane 2 SHOW, oe_n=1 and plane=0. The FSM returns to IDLE and hub75_ready=1 on the next edge.
//  - addr holds its value between pairs. oe_n is never low during LATCH or SHIFT, which prevents ghosting.
//  - Plane counter is 2 bits and wraps 2->0 only at exit. The OE counter width fits BASE_OE_CYCLES<<2.
//  - Reset mid-operation (any state): abort the pair, drop the buffer, apply reset values; no partial latch.
// CONFIGURATION
//  LINE_DBUF_EN defined:
//    - Two line buffers (front/back). hub75_ready=1 whenever the back buffer is empty, including during SHIFT/LATCH/SHOW.
//    - On exit with the back buffer full, swap and enter SHIFT of plane 0 on the next cycle, with no IDLE cycle.
//    - A capture on the same edge as the swap fills the back buffer; the pair is not lost.
//  LINE_DBUF_EN undefined:
//    - Single buffer. hub75_ready=1 only in IDLE.
//    - Minimum pair period = 1 capture + 1 IDLE + 443 cycles (default parameters).
// TESTING
//  1. rst_in=0 mid-stream -> same-cycle oe_n=1, latch=0, sclk=0, ready=0. Release -> ready=1 after 1 edge.
//  2. All pixels 9'h1FF, col_num=5 -> 64 sclk rises per plane, rgb1/2=1.
//     addr=5 at each latch; oe_n low runs of 8,16,32 cycles; ready back after 443.
//  3. Pixel0 upper=9'b101_010_001, lower=0 -> plane0 r1g1b1=101, plane1=010, plane2=100; r2g2b2=000.
//  4. data_valid held high, col_num stepping 0..31 -> exactly one capture per ready window.
//     addr sequence 0,1,..,31 then wraps to 0; oe_n never low while latch=1 or sclk toggles.
//  5. Reset during plane-1 SHOW then release -> no latch pulse before the next capture.
//     The next pair displays from plane 0.
//  6. LINE_DBUF_EN, two pairs back-to-back -> ready stays high during the first pair.
//     The second pair's first SHIFT cycle immediately follows the first pair's last SHOW cycle.

Source files
------------

// File: rtl/hub75_line_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hub75_line_driver                                            |
// | Description : Takes one scanline pair (upper and lower 64-pixel columns)   |
// |               and drives the HUB75 pins. Three bit-planes are shown with   |
// |               binary-coded modulation: shift the plane, latch it, then     |
// |               hold OE low for BASE_OE_CYCLES << plane cycles.              |
// |               Build macro LINE_DBUF_EN selects a front/back line buffer,   |
// |               so the next pair can be accepted while the current one is    |
// |               being displayed.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hub75_line_driver #(
  parameter int NUM_ROWS       = 64,
  parameter int SCAN_RATE      = 32,
  parameter int RGB_RES        = 9,
  parameter int BASE_OE_CYCLES = 8
) (
  input  logic                                    clk_in,
  input  logic                                    rst_in,
  input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]   columns,
  input  logic [$clog2(SCAN_RATE)-1:0]            col_num,
  input  logic                                    data_valid,
  output logic                                    hub75_ready,
  output logic                                    r1,
  output logic                                    g1,
  output logic                                    b1,
  output logic                                    r2,
  output logic                                    g2,
  output logic                                    b2,
  output logic                                    sclk,
  output logic                                    latch,
  output logic                                    oe_n,
  output logic [$clog2(SCAN_RATE)-1:0]            addr
);

  localparam int ADDR_W = $clog2(SCAN_RATE);
  localparam int PIX_W  = $clog2(NUM_ROWS);
  localparam int CH_W   = RGB_RES / 3;
  // One counter serves both the shift phase (2 cycles per pixel) and the OE hold.
  localparam int SH_W   = PIX_W + 1;
  localparam int OE_W   = $clog2(BASE_OE_CYCLES * 4);
  localparam int CNT_W  = (SH_W > OE_W) ? SH_W : OE_W;

  localparam logic [CNT_W-1:0] C_SHIFT_LAST = CNT_W'(2 * NUM_ROWS - 1);
  localparam logic [1:0]       C_LAST_PLANE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  typedef logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] line_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [1:0]          r_plane;
  logic [1:0]          w_plane_nxt;
  logic [CNT_W-1:0]    w_oe_last;
  logic                r_pend;       // a captured pair is waiting to be displayed
  logic                w_pend_nxt;
  logic                w_cap;        // pair accepted on this edge
  logic                w_start;      // display of the pending pair begins on this edge
  logic                r_ready;
  logic                w_ready_nxt;

  line_t               w_disp_nxt;   // buffer being displayed after this edge
  logic [ADDR_W-1:0]   w_num_nxt;

  logic                r_oe_n;
  logic                r_latch;
  logic                r_sclk;
  logic [5:0]          r_rgb;
  logic [ADDR_W-1:0]   r_addr;

  logic [PIX_W-1:0]    w_pix;
  logic [RGB_RES-1:0]  w_px_u;
  logic [RGB_RES-1:0]  w_px_l;
  logic [CH_W-1:0]     w_r_u, w_g_u, w_b_u;
  logic [CH_W-1:0]     w_r_l, w_g_l, w_b_l;
  logic [5:0]          w_rgb_nxt;

  assign w_cap      = r_ready && data_valid;
  // A capture on the same edge as a start refills the slot, so capture wins.
  assign w_pend_nxt = w_cap | (r_pend & ~w_start);
  assign w_oe_last  = CNT_W'((BASE_OE_CYCLES << r_plane) - 1);

`ifdef LINE_DBUF_EN
  line_t             r_back;
  line_t             r_front;
  logic [ADDR_W-1:0] r_back_num;
  logic [ADDR_W-1:0] r_front_num;

  // Back buffer takes new pairs; it moves to the front when display of it starts.
  always_ff @(posedge clk_in) begin
    if (w_cap) begin
      r_back     <= columns;
      r_back_num <= col_num;
    end
    if (w_start) begin
      r_front     <= r_back;
      r_front_num <= r_back_num;
    end
  end

  assign w_disp_nxt  = w_start ? r_back : r_front;
  assign w_num_nxt   = w_start ? r_back_num : r_front_num;
  assign w_ready_nxt = ~w_pend_nxt;
`else
  line_t             r_buf;
  logic [ADDR_W-1:0] r_buf_num;

  // Single line buffer; only written while idle, so it is stable during display.
  always_ff @(posedge clk_in) begin
    if (w_cap) begin
      r_buf     <= columns;
      r_buf_num <= col_num;
    end
  end

  assign w_disp_nxt  = r_buf;
  assign w_num_nxt   = r_buf_num;
  assign w_ready_nxt = (w_state_nxt == S_IDLE) && ~w_pend_nxt;
`endif

  // Next-state, counter and plane sequencing for shift / latch / show.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_plane_nxt = r_plane;
    w_start     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_plane_nxt = '0;
          w_start     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == C_SHIFT_LAST) begin
          w_state_nxt = S_LATCH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_LATCH: begin
        w_state_nxt = S_SHOW;
        w_cnt_nxt   = '0;
      end
      S_SHOW: begin
        if (r_cnt == w_oe_last) begin
          w_cnt_nxt = '0;
          if (r_plane == C_LAST_PLANE) begin
            w_plane_nxt = '0;
            // With a pair already waiting, go straight into its first shift.
            if (r_pend) begin
              w_state_nxt = S_SHIFT;
              w_start     = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_plane_nxt = r_plane + 2'd1;
            w_state_nxt = S_SHIFT;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Pixel and bit-plane selection for the data presented after this edge.
  assign w_pix  = w_cnt_nxt[PIX_W:1];
  assign w_px_u = w_disp_nxt[0][w_pix];
  assign w_px_l = w_disp_nxt[1][w_pix];
  assign w_r_u  = w_px_u[3*CH_W-1:2*CH_W];
  assign w_g_u  = w_px_u[2*CH_W-1:CH_W];
  assign w_b_u  = w_px_u[CH_W-1:0];
  assign w_r_l  = w_px_l[3*CH_W-1:2*CH_W];
  assign w_g_l  = w_px_l[2*CH_W-1:CH_W];
  assign w_b_l  = w_px_l[CH_W-1:0];
  assign w_rgb_nxt = {w_r_u[w_plane_nxt], w_g_u[w_plane_nxt], w_b_u[w_plane_nxt],
                      w_r_l[w_plane_nxt], w_g_l[w_plane_nxt], w_b_l[w_plane_nxt]};

  // State register plus glitch-free registered panel pins; reset blanks the panel at once.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_plane <= '0;
      r_pend  <= 1'b0;
      r_ready <= 1'b0;
      r_oe_n  <= 1'b1;
      r_latch <= 1'b0;
      r_sclk  <= 1'b0;
      r_rgb   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_plane <= w_plane_nxt;
      r_pend  <= w_pend_nxt;
      r_ready <= w_ready_nxt;
      r_oe_n  <= (w_state_nxt != S_SHOW);
      r_latch <= (w_state_nxt == S_LATCH);
      r_sclk  <= (w_state_nxt == S_SHIFT) && w_cnt_nxt[0];
      r_rgb   <= (w_state_nxt == S_SHIFT) ? w_rgb_nxt : 6'd0;
      if (w_state_nxt == S_LATCH) begin
        r_addr <= w_num_nxt;
      end
    end
  end

  assign hub75_ready = r_ready;
  assign oe_n        = r_oe_n;
  assign latch       = r_latch;
  assign sclk        = r_sclk;
  assign addr        = r_addr;
  assign {r1, g1, b1, r2, g2, b2} = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_hub75_line_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hub75_line_driver                                         |
// | Description : Scoreboard bench for hub75_line_driver. Each accepted pair   |
// |               pushes its expected shift words, latch addresses and OE run  |
// |               lengths; a negedge monitor pops and compares as the panel    |
// |               pins show them. Honours LINE_DBUF_EN for the timing checks.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_hub75_line_driver;

  localparam int NUM_ROWS  = 64;
  localparam int SCAN_RATE = 32;
  localparam int RGB_RES   = 9;
  localparam int BASE_OE   = 8;
  localparam int AW        = 5;
  // Edges from the capture edge until hub75_ready is seen high again:
  // one idle cycle, 3 planes of (shift+latch), the three OE holds, then the exit edge.
  localparam int LAT = 1 + 3 * (2 * NUM_ROWS + 1) + BASE_OE * (1 + 2 + 4);

  typedef logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] line_t;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  line_t         columns = '0;
  logic [AW-1:0] col_num = '0;
  logic          data_valid = 1'b0;
  logic          hub75_ready;
  logic          r1, g1, b1, r2, g2, b2;
  logic          sclk, latch, oe_n;
  logic [AW-1:0] addr;

  hub75_line_driver #(
    .NUM_ROWS(NUM_ROWS), .SCAN_RATE(SCAN_RATE), .RGB_RES(RGB_RES), .BASE_OE_CYCLES(BASE_OE)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .columns(columns), .col_num(col_num),
    .data_valid(data_valid), .hub75_ready(hub75_ready),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .sclk(sclk), .latch(latch), .oe_n(oe_n), .addr(addr)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0]  q_shift[$];
  int          q_addr[$];
  int          q_oe[$];
  int unsigned q_cap[$];
  int unsigned last_cap = 0;

  bit   mon_en = 1'b0;
  logic prev_sclk = 1'b0;
  logic prev_ready = 1'b0;
  int   oe_run = 0;
  int   rises = 0;
  bit   expect_rise = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: bit p of each 3-bit channel of a 9-bit pixel, R G B order.
  function automatic logic [2:0] plane_bits(input int pix, input int p);
    int r, g, b;
    r = pix / 64;
    g = (pix / 8) % 8;
    b = pix % 8;
    return {((r >> p) % 2) == 1, ((g >> p) % 2) == 1, ((b >> p) % 2) == 1};
  endfunction

  task automatic push_pair(input line_t c, input int num);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NUM_ROWS; i++)
        q_shift.push_back({plane_bits(int'(c[0][i]), p), plane_bits(int'(c[1][i]), p)});
      q_addr.push_back(num);
      q_oe.push_back(BASE_OE * (2 ** p));
    end
    q_cap.push_back(cyc + 1);
    last_cap = cyc + 1;
  endtask

  task automatic gen_line(output line_t c);
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < NUM_ROWS; i++)
        c[h][i] = 9'($urandom_range(0, 511));
  endtask

  // Monitor: pops expectations as shift rises, latch pulses and OE runs appear.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (expect_rise) begin
        check("dbuf_back_to_back_shift", {63'd0, sclk && !prev_sclk}, 64'd1);
        expect_rise = 1'b0;
      end
      if (latch || sclk) check("oe_blank_while_latch_or_sclk", {63'd0, oe_n}, 64'd1);
      if (!oe_n) check("rgb_zero_in_show", {58'd0, r1, g1, b1, r2, g2, b2}, 64'd0);
      if (sclk && !prev_sclk) begin
        rises++;
        if (q_shift.size() == 0) fail("unexpected_shift_rise");
        else check("shift_rgb", {58'd0, r1, g1, b1, r2, g2, b2}, {58'd0, q_shift.pop_front()});
      end
      if (latch) begin
        check("rises_per_plane", rises, NUM_ROWS);
        rises = 0;
        if (q_addr.size() == 0) fail("unexpected_latch");
        else check("latch_addr", addr, q_addr.pop_front());
      end
      if (!oe_n) oe_run++;
      else if (oe_run > 0) begin
        if (q_oe.size() == 0) fail("unexpected_oe_run");
        else begin
          int e;
          e = q_oe.pop_front();
          check("oe_run_len", oe_run, e);
`ifdef LINE_DBUF_EN
          if (e == BASE_OE * 4 && q_shift.size() > 0 && last_cap < cyc) expect_rise = 1'b1;
`endif
        end
        oe_run = 0;
      end
`ifndef LINE_DBUF_EN
      if (hub75_ready && !prev_ready && q_cap.size() > 0 && q_cap[0] <= cyc)
        check("pair_latency", cyc - q_cap.pop_front(), LAT);
`endif
      prev_sclk  = sclk;
      prev_ready = hub75_ready;
    end
  end

  // Offer pairs until n have been accepted; ready is stable at the negedge.
  task automatic stream(input int n, input bit hold, input bit step, input int start_num,
                        input bit use_first, input line_t first);
    int    sent;
    int    budget;
    int    num;
    line_t cur;
    sent   = 0;
    budget = n * (LAT + 40) + 200;
    num    = start_num;
    if (use_first) cur = first;
    else gen_line(cur);
    while (sent < n && budget > 0) begin
      @(negedge clk_in);
      budget--;
      columns    = cur;
      col_num    = AW'(num);
      data_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (data_valid && hub75_ready) begin
        push_pair(cur, num);
        sent++;
        gen_line(cur);
        num = step ? (num + 1) % SCAN_RATE : int'($urandom_range(0, SCAN_RATE - 1));
      end
    end
    @(negedge clk_in);
    data_valid = 1'b0;
    if (sent < n) fail("stream_timeout");
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q_oe.size() > 0 && k < 3 * LAT) begin
      @(negedge clk_in);
      k++;
    end
    repeat (4) @(negedge clk_in);
    check("drain_oe_queue_empty", q_oe.size(), 0);
  endtask

  task automatic reset_pulse();
    data_valid = 1'b0;
    @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    mon_en = 1'b0;
    #1;
    check("rst_oe_n", {63'd0, oe_n}, 64'd1);
    check("rst_latch", {63'd0, latch}, 64'd0);
    check("rst_sclk", {63'd0, sclk}, 64'd0);
    check("rst_ready", {63'd0, hub75_ready}, 64'd0);
    q_shift.delete(); q_addr.delete(); q_oe.delete(); q_cap.delete();
    oe_run = 0; rises = 0; expect_rise = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("ready_after_release", {63'd0, hub75_ready}, 64'd1);
    prev_sclk  = 1'b0;
    prev_ready = hub75_ready;
    mon_en     = 1'b1;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t d;
    int    nl;

    // Power-on reset values.
    #1 rst_in = 1'b0;
    #1;
    check("por_ready", {63'd0, hub75_ready}, 64'd0);
    check("por_oe_n", {63'd0, oe_n}, 64'd1);
    check("por_latch", {63'd0, latch}, 64'd0);
    check("por_sclk", {63'd0, sclk}, 64'd0);
    check("por_addr", addr, 64'd0);
    check("por_rgb", {58'd0, r1, g1, b1, r2, g2, b2}, 64'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("por_ready_after_release", {63'd0, hub75_ready}, 64'd1);
    prev_ready = hub75_ready;
    mon_en = 1'b1;

    // All-white pair on scanline 5.
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < NUM_ROWS; i++) d[h][i] = 9'h1FF;
    stream(1, 1'b1, 1'b0, 5, 1'b1, d);
    drain();

    // Per-plane bit order on pixel 0, lower half dark.
    gen_line(d);
    for (int i = 0; i < NUM_ROWS; i++) d[1][i] = 9'h000;
    d[0][0] = 9'b101_010_001;
    stream(1, 1'b1, 1'b0, 17, 1'b1, d);
    drain();

    // Random pairs with gappy data_valid.
    stream(4, 1'b0, 1'b0, int'($urandom_range(0, SCAN_RATE - 1)), 1'b0, d);
    drain();

    // data_valid held high, addresses stepping 0..31 and wrapping to 0.
    stream(SCAN_RATE + 1, 1'b1, 1'b1, 0, 1'b0, d);
    drain();

    // Reset in the middle of a pair.
    stream(1, 1'b1, 1'b0, 9, 1'b0, d);
    repeat ($urandom_range(20, 200)) @(negedge clk_in);
    reset_pulse();

    // Reset during plane-1 OE hold; nothing latches until the next pair.
    stream(1, 1'b1, 1'b0, 22, 1'b0, d);
    nl = 0;
    for (int k = 0; k < 2 * LAT && nl < 2; k++) begin
      @(negedge clk_in);
      if (latch) nl++;
    end
    check("reached_plane1", nl, 2);
    repeat (5) @(negedge clk_in);
    reset_pulse();
    nl = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk_in);
      if (latch) nl++;
    end
    check("no_latch_after_abort", nl, 0);
    stream(1, 1'b1, 1'b0, 30, 1'b0, d);
    drain();

    // Two pairs offered back to back.
    stream(2, 1'b1, 1'b0, 3, 1'b0, d);
    drain();

    check("final_shift_queue_empty", q_shift.size(), 0);
    check("final_addr_queue_empty", q_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
